// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and default parameters for the data-memory responder.
//   state_e      : responder FSM states (IDLE, BUSY, DONE), 2-bit encoding
//   *_DEF params : default widths, array depth, line size and miss latency
package dmem_pkg;

  localparam int ADDR_W_DEF     = 16;
  localparam int DATA_W_DEF     = 16;
  localparam int DEPTH_LOG2_DEF = 8;
  localparam int LINE_LOG2_DEF  = 2;
  localparam int MISS_LAT_DEF   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/dmem_array.sv
// dmem_array: word-addressed storage with asynchronous read and synchronous write.
//   clk   in  : write clock
//   we    in  : write enable, commits wdata at the rising edge
//   waddr in  : write word index
//   wdata in  : write data
//   raddr in  : read word index
//   rdata out : array[raddr], combinational
// Contents are not reset.
module dmem_array #(
  parameter int DEPTH_LOG2 = 8,
  parameter int DATA_W     = 16
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [DATA_W-1:0]     rdata
);

  logic [DATA_W-1:0] mem_q [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: responder end of the Memory-stage data-memory interface.
// A single-line buffer gives same-cycle hits; anything else takes a fixed
// MISS_LAT-cycle miss path, after which the line buffer holds the missed line.
//   clk      in  : system clock
//   rst_n    in  : synchronous reset, active low
//   Addr     in  : byte address (bit 0 must be 0 on a request)
//   DataIn   in  : write data
//   Rd, Wr   in  : read / write request
//   DataOut  out : read data, nonzero only on a completing read
//   Done     out : request completes this cycle
//   Stall    out : request in progress, requester holds its inputs
//   CacheHit out : completion was a line-buffer hit
//   err      out : protocol error this cycle
// Handshake: a request is Rd|Wr held stable until the cycle Done=1; Done and
// Stall are never both high, and the next request may follow in the cycle after.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF,
  parameter int LINE_LOG2  = LINE_LOG2_DEF,
  parameter int MISS_LAT   = MISS_LAT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [DATA_W-1:0] DataIn,
  input  logic              Rd,
  input  logic              Wr,
  output logic [DATA_W-1:0] DataOut,
  output logic              Done,
  output logic              Stall,
  output logic              CacheHit,
  output logic              err
);

  localparam int TAG_W = ADDR_W - LINE_LOG2 - 1;
  localparam int CNT_W = (MISS_LAT > 2) ? $clog2(MISS_LAT) : 1;

  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [ADDR_W-1:0]   lat_addr_q;
  logic [DATA_W-1:0]   lat_data_q;
  logic                lat_rd_q;
  logic                lat_wr_q;
  logic                line_valid_q;
  logic [TAG_W-1:0]    line_tag_q;

  logic                proto_err;
  logic                busy_mismatch;
  logic                req_ok;
  logic                tag_hit;
  logic                idle_hit;
  logic                idle_miss;
  logic                in_done;
  logic                arr_we_d;
  logic [DEPTH_LOG2-1:0] arr_idx_d;
  logic [DATA_W-1:0]   arr_wdata_d;
  logic [DATA_W-1:0]   arr_rdata;

  assign proto_err     = (Rd & Wr) | (Addr[0] & (Rd | Wr));
  // While a miss is outstanding the requester must hold everything it issued.
  assign busy_mismatch = (state_q == BUSY) &&
                         ((Addr != lat_addr_q) || (DataIn != lat_data_q) ||
                          (Rd != lat_rd_q) || (Wr != lat_wr_q));
  assign err           = proto_err | busy_mismatch;

  assign req_ok    = (Rd | Wr) & ~proto_err;
  assign tag_hit   = line_valid_q && (Addr[ADDR_W-1:LINE_LOG2+1] == line_tag_q);
  assign idle_hit  = (state_q == IDLE) && req_ok && tag_hit;
  assign idle_miss = (state_q == IDLE) && req_ok && !tag_hit;
  assign in_done   = (state_q == DONE);

  // In DONE the array is driven from the latched request, so a requester that
  // dropped or changed its inputs during BUSY still gets the original access.
  assign arr_idx_d   = in_done ? lat_addr_q[DEPTH_LOG2:1] : Addr[DEPTH_LOG2:1];
  assign arr_wdata_d = in_done ? lat_data_q : DataIn;
  assign arr_we_d    = rst_n & ((idle_hit & Wr) | (in_done & lat_wr_q));

  dmem_array #(
    .DEPTH_LOG2(DEPTH_LOG2),
    .DATA_W    (DATA_W)
  ) u_array (
    .clk  (clk),
    .we   (arr_we_d),
    .waddr(arr_idx_d),
    .wdata(arr_wdata_d),
    .raddr(arr_idx_d),
    .rdata(arr_rdata)
  );

  assign Done     = idle_hit | in_done;
  assign Stall    = idle_miss | (state_q == BUSY);
  assign CacheHit = idle_hit;
  assign DataOut  = ((idle_hit & Rd) | (in_done & lat_rd_q)) ? arr_rdata : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      lat_addr_q   <= '0;
      lat_data_q   <= '0;
      lat_rd_q     <= 1'b0;
      lat_wr_q     <= 1'b0;
      line_valid_q <= 1'b0;
      line_tag_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (idle_miss) begin
            lat_addr_q <= Addr;
            lat_data_q <= DataIn;
            lat_rd_q   <= Rd;
            lat_wr_q   <= Wr;
            // Request cycle plus (MISS_LAT-2)+1 BUSY cycles puts DONE at MISS_LAT.
            cnt_q      <= CNT_W'(MISS_LAT - 2);
            state_q    <= BUSY;
          end
        end
        BUSY: begin
          if (cnt_q == '0) begin
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        DONE: begin
          line_tag_q   <= lat_addr_q[ADDR_W-1:LINE_LOG2+1];
          line_valid_q <= 1'b1;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  localparam int MISS_LAT = 4;

  logic        clk;
  logic        rst_n;
  logic [15:0] Addr;
  logic [15:0] DataIn;
  logic        Rd;
  logic        Wr;
  logic [15:0] DataOut;
  logic        Done;
  logic        Stall;
  logic        CacheHit;
  logic        err;

  int total;
  int bad;

  dmem_responder dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .Addr    (Addr),
    .DataIn  (DataIn),
    .Rd      (Rd),
    .Wr      (Wr),
    .DataOut (DataOut),
    .Done    (Done),
    .Stall   (Stall),
    .CacheHit(CacheHit),
    .err     (err)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // inputs change 1 time unit after the edge, outputs are sampled mid-cycle
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #4;
  endtask

  task automatic drive(input logic [15:0] a, input logic [15:0] d, input logic r, input logic w);
    Addr   = a;
    DataIn = d;
    Rd     = r;
    Wr     = w;
  endtask

  task automatic drive_idle();
    drive(16'h0000, 16'h0000, 1'b0, 1'b0);
  endtask

  task automatic check_quiet(input string tag);
    check_eq({tag, ".dout"},  DataOut,  0);
    check_eq({tag, ".done"},  Done,     0);
    check_eq({tag, ".stall"}, Stall,    0);
    check_eq({tag, ".hit"},   CacheHit, 0);
    check_eq({tag, ".err"},   err,      0);
  endtask

  // Same-cycle line-buffer hit; exp_dout is 0 for writes.
  task automatic do_hit(input string tag, input logic [15:0] a, input logic [15:0] d,
                        input logic r, input logic w, input logic [15:0] exp_dout);
    drive(a, d, r, w);
    settle();
    check_eq({tag, ".done"},  Done,     1);
    check_eq({tag, ".hit"},   CacheHit, 1);
    check_eq({tag, ".stall"}, Stall,    0);
    check_eq({tag, ".dout"},  DataOut,  exp_dout);
    tick();
    drive_idle();
  endtask

  // Miss with inputs held: Stall for cycles 0..MISS_LAT-1, Done at MISS_LAT.
  task automatic do_miss(input string tag, input logic [15:0] a, input logic [15:0] d,
                         input logic r, input logic w, input logic chk_dout,
                         input logic [15:0] exp_dout);
    drive(a, d, r, w);
    for (int c = 0; c < MISS_LAT; c++) begin
      settle();
      check_eq({tag, ".stall"}, Stall, 1);
      check_eq({tag, ".done"},  Done,  0);
      tick();
    end
    settle();
    check_eq({tag, ".done_end"},  Done,     1);
    check_eq({tag, ".stall_end"}, Stall,    0);
    check_eq({tag, ".hit_end"},   CacheHit, 0);
    check_eq({tag, ".err_end"},   err,      0);
    if (chk_dout) check_eq({tag, ".dout"}, DataOut, exp_dout);
    tick();
    drive_idle();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    drive_idle();
    tick();
    tick();
    rst_n = 1'b1;
    settle();
    check_quiet("reset");
    tick();

    // cold read: contents unknown, only timing is checked
    do_miss("cold_rd", 16'h0010, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000);
    do_hit("wr_hit_12", 16'h0012, 16'hBEEF, 1'b0, 1'b1, 16'h0000);
    do_hit("rd_hit_12", 16'h0012, 16'h0000, 1'b1, 1'b0, 16'hBEEF);
    do_hit("wr_hit_10", 16'h0010, 16'h1111, 1'b0, 1'b1, 16'h0000);
    do_hit("rd_hit_10", 16'h0010, 16'h0000, 1'b1, 1'b0, 16'h1111);

    // new line, then back to the old line misses again
    do_miss("wr_miss_20", 16'h0020, 16'h2222, 1'b0, 1'b1, 1'b1, 16'h0000);
    do_hit("rd_hit_20", 16'h0020, 16'h0000, 1'b1, 1'b0, 16'h2222);
    do_miss("rd_miss_10", 16'h0010, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h1111);

    // protocol errors are dropped
    drive(16'h0011, 16'h0000, 1'b1, 1'b0);
    settle();
    check_eq("odd_addr.err",   err,   1);
    check_eq("odd_addr.stall", Stall, 0);
    check_eq("odd_addr.done",  Done,  0);
    tick();
    drive(16'h0010, 16'h9999, 1'b1, 1'b1);
    settle();
    check_eq("rd_wr.err",   err,   1);
    check_eq("rd_wr.stall", Stall, 0);
    check_eq("rd_wr.done",  Done,  0);
    tick();
    drive_idle();
    do_hit("after_err", 16'h0010, 16'h0000, 1'b1, 1'b0, 16'h1111);

    // aliasing of upper index bits
    do_miss("wr_alias", 16'h0200, 16'h1234, 1'b0, 1'b1, 1'b1, 16'h0000);
    do_miss("rd_alias", 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h1234);

    // Addr changed mid-BUSY: err while different, original read completes
    drive(16'h0012, 16'h0000, 1'b1, 1'b0);
    settle();
    check_eq("chg_addr.stall0", Stall, 1);
    tick();
    Addr = 16'h0040;
    settle();
    check_eq("chg_addr.err1",   err,   1);
    check_eq("chg_addr.stall1", Stall, 1);
    check_eq("chg_addr.done1",  Done,  0);
    tick();
    Addr = 16'h0012;
    settle();
    check_eq("chg_addr.err2",   err,   0);
    check_eq("chg_addr.stall2", Stall, 1);
    tick();
    settle();
    check_eq("chg_addr.stall3", Stall, 1);
    tick();
    settle();
    check_eq("chg_addr.done4", Done,    1);
    check_eq("chg_addr.dout4", DataOut, 16'hBEEF);
    tick();
    drive_idle();

    // Wr dropped mid-BUSY: write still commits
    drive(16'h0030, 16'h5555, 1'b0, 1'b1);
    settle();
    check_eq("drop_wr.stall0", Stall, 1);
    tick();
    Wr = 1'b0;
    for (int c = 1; c < MISS_LAT; c++) begin
      settle();
      check_eq("drop_wr.err",   err,   1);
      check_eq("drop_wr.stall", Stall, 1);
      tick();
    end
    settle();
    check_eq("drop_wr.done", Done,    1);
    check_eq("drop_wr.dout", DataOut, 0);
    tick();
    drive_idle();
    do_hit("rd_hit_30", 16'h0030, 16'h0000, 1'b1, 1'b0, 16'h5555);

    // reset mid-BUSY aborts the write and invalidates the line
    drive(16'h0010, 16'h7777, 1'b0, 1'b1);
    settle();
    check_eq("rst_mid.stall0", Stall, 1);
    tick();
    rst_n = 1'b0;
    drive_idle();
    tick();
    tick();
    rst_n = 1'b1;
    settle();
    check_quiet("rst_mid");
    tick();
    do_miss("rd_30_after_rst", 16'h0030, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h5555);
    do_miss("rd_10_after_rst", 16'h0010, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h1111);

    settle();
    check_quiet("final_idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
